// File: rtl/prescaled_counter.sv
// Parametrised prescaled up/down counter with tick and wrap pulses.
// Define PRESCALED_COUNTER_SAT_EN to saturate at the count limits instead of wrapping.
module prescaled_counter #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 50000000,
    parameter int MODULUS  = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             wrap
);

    localparam int PS_WIDTH = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PS_WIDTH-1:0] PS_LAST = PS_WIDTH'(PRESCALE - 1);
    localparam logic [WIDTH-1:0]    CNT_MAX = WIDTH'(MODULUS - 1);
    // One bit wider so MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0]      MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [PS_WIDTH-1:0] ps_q, ps_d;
    logic [WIDTH-1:0]    count_q, count_d;
    logic                tick_q, tick_d;
    logic                wrap_q, wrap_d;

    logic                step;
    logic [WIDTH-1:0]    step_val;
    logic                step_wrap;
    logic [WIDTH-1:0]    load_clamped;

    always_comb begin
        step         = en && (ps_q == PS_LAST);
        load_clamped = ({1'b0, load_val} >= MOD_EXT) ? CNT_MAX : load_val;
`ifdef PRESCALED_COUNTER_SAT_EN
        // wrap marks arrival at the limit; steps taken while already there give tick only.
        if (up_dn) begin
            step_val  = (count_q == CNT_MAX) ? CNT_MAX : count_q + WIDTH'(1);
            step_wrap = (count_q == CNT_MAX - WIDTH'(1));
        end else begin
            step_val  = (count_q == '0) ? '0 : count_q - WIDTH'(1);
            step_wrap = (count_q == WIDTH'(1));
        end
`else
        if (up_dn) begin
            step_val  = (count_q == CNT_MAX) ? '0 : count_q + WIDTH'(1);
            step_wrap = (count_q == CNT_MAX);
        end else begin
            step_val  = (count_q == '0) ? CNT_MAX : count_q - WIDTH'(1);
            step_wrap = (count_q == '0);
        end
`endif
    end

    always_comb begin
        ps_d    = ps_q;
        count_d = count_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (clr) begin
            ps_d    = '0;
            count_d = '0;
        end else begin
            if (en) begin
                ps_d = step ? '0 : ps_q + PS_WIDTH'(1);
            end
            // The prescaler keeps its phase through a load, so tick still fires.
            tick_d = step;
            if (load) begin
                count_d = load_clamped;
            end else if (step) begin
                count_d = step_val;
                wrap_d  = step_wrap;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ps_q    <= '0;
            count_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            ps_q    <= ps_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign tick  = tick_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_prescaled_counter.sv
// Self-checking bench for prescaled_counter (WIDTH=4, PRESCALE=4, MODULUS=10).
// Honours PRESCALED_COUNTER_SAT_EN in its reference model and directed expectations.
module tb_prescaled_counter;

    localparam int W   = 4;
    localparam int PRE = 4;
    localparam int MOD = 10;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         up_dn;
    logic         clr;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic         tick;
    logic         wrap;

    int checks = 0;
    int errors = 0;
    int tick_seen = 0;
    int wrap_seen = 0;

    // Reference model state: prescaler phase, count value and the two pulses.
    int   m_ps = 0;
    int   m_cnt = 0;
    logic m_tick = 1'b0;
    logic m_wrap = 1'b0;

    prescaled_counter #(
        .WIDTH    (W),
        .PRESCALE (PRE),
        .MODULUS  (MOD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up_dn    (up_dn),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tick     (tick),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_step(input logic r, input logic e, input logic u, input logic c,
                              input logic l, input int lv);
        bit step;
        int nxt;
        if (!r || c) begin
            m_ps   = 0;
            m_cnt  = 0;
            m_tick = 1'b0;
            m_wrap = 1'b0;
        end else begin
            step   = e && (m_ps == PRE - 1);
            if (e) m_ps = (m_ps + 1) % PRE;
            m_tick = step;
            m_wrap = 1'b0;
            if (l) begin
                m_cnt = (lv >= MOD) ? MOD - 1 : lv;
            end else if (step) begin
`ifdef PRESCALED_COUNTER_SAT_EN
                nxt    = u ? ((m_cnt + 1 > MOD - 1) ? MOD - 1 : m_cnt + 1)
                           : ((m_cnt == 0) ? 0 : m_cnt - 1);
                m_wrap = (nxt != m_cnt) && (nxt == (u ? MOD - 1 : 0));
`else
                nxt    = u ? (m_cnt + 1) % MOD : (m_cnt + MOD - 1) % MOD;
                m_wrap = (nxt == (u ? 0 : MOD - 1));
`endif
                m_cnt = nxt;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, compare 1 time unit later.
    task automatic cyc(input logic r, input logic e, input logic u, input logic c,
                       input logic l, input logic [W-1:0] lv);
        rst_n    = r;
        en       = e;
        up_dn    = u;
        clr      = c;
        load     = l;
        load_val = lv;
        @(posedge clk);
        model_step(r, e, u, c, l, int'(lv));
        #1;
        chk("count", 32'(count), m_cnt);
        chk("tick", 32'(tick), int'(m_tick));
        chk("wrap", 32'(wrap), int'(m_wrap));
        chk("range", 32'(count < W'(MOD)), 1);
        if (tick === 1'b1) tick_seen++;
        if (wrap === 1'b1) wrap_seen++;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;

        // Reset
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        chk("reset_count", 32'(count), 0);
        chk("reset_tick", 32'(tick), 0);
        chk("reset_wrap", 32'(wrap), 0);

        // Free-run up for 44 cycles: 11 steps, one boundary event
        tick_seen = 0; wrap_seen = 0;
        for (int i = 0; i < 44; i++) cyc(1, 1, 1, 0, 0, 0);
        chk("up44_ticks", 32'(tick_seen), 11);
        chk("up44_wraps", 32'(wrap_seen), 1);
`ifdef PRESCALED_COUNTER_SAT_EN
        chk("up44_final", 32'(count), 9);
`else
        chk("up44_final", 32'(count), 1);
`endif

        // Count down from 0
        cyc(1, 1, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0, 0);
`ifdef PRESCALED_COUNTER_SAT_EN
        chk("down_first", 32'(count), 0);
        chk("down_wrap", 32'(wrap), 0);
`else
        chk("down_first", 32'(count), 9);
        chk("down_wrap", 32'(wrap), 1);
`endif
        for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0, 0, 0);
`ifdef PRESCALED_COUNTER_SAT_EN
        chk("down_third", 32'(count), 0);
`else
        chk("down_third", 32'(count), 7);
`endif

        // Enable gap at prescaler phase 2
        cyc(1, 1, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0, 0);
        chk("gap_hold", 32'(count), 0);
        cyc(1, 1, 1, 0, 0, 0);
        chk("gap_no_tick", 32'(tick), 0);
        cyc(1, 1, 1, 0, 0, 0);
        chk("gap_tick", 32'(tick), 1);
        chk("gap_count", 32'(count), 1);

        // Load coincident with a step, then an out-of-range load
        cyc(1, 1, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 1, 7);
        chk("load_step_count", 32'(count), 7);
        chk("load_step_tick", 32'(tick), 1);
        chk("load_step_wrap", 32'(wrap), 0);
        cyc(1, 1, 1, 0, 1, 13);
        chk("load_clamp", 32'(count), 9);

        // Clear at prescaler phase 3 with count 5
        cyc(1, 1, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 1, 5);
        cyc(1, 1, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0);
        cyc(1, 1, 1, 1, 0, 0);
        chk("clr_count", 32'(count), 0);
        chk("clr_tick", 32'(tick), 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0, 0);
        chk("clr_no_tick", 32'(tick), 0);
        cyc(1, 1, 1, 0, 0, 0);
        chk("clr_next_tick", 32'(tick), 1);

        // Reset mid-count
        for (int i = 0; i < 6; i++) cyc(1, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        chk("rst_mid_count", 32'(count), 0);
        chk("rst_mid_tick", 32'(tick), 0);

`ifdef PRESCALED_COUNTER_SAT_EN
        // Saturation at the top
        cyc(1, 1, 1, 1, 0, 0);
        cyc(1, 0, 1, 0, 1, 8);
        for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0, 0, 0);
        chk("sat_reach", 32'(count), 9);
        chk("sat_reach_wrap", 32'(wrap), 1);
        for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0, 0, 0);
        chk("sat_hold", 32'(count), 9);
        chk("sat_hold_tick", 32'(tick), 1);
        chk("sat_hold_wrap", 32'(wrap), 0);
`endif

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
                $urandom_range(0, 29) == 0, $urandom_range(0, 14) == 0,
                W'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prescaled_counter.md
Name: prescaled_counter

Overview:
- Parametrised successor to the fixed 8-bit free-running counter with its built-in frequency divider.
- Generalised width, prescale ratio and modulus.
- Adds up/down direction, enable, synchronous clear, parallel load, tick output and wrap pulse.
- Used as a slow visible counter for board LEDs/7-seg drivers, and as a reusable timebase generator for other blocks.

Parameters:
- WIDTH, 8, counter width in bits.
- PRESCALE, 50000000, clk cycles per count step; legal range >= 1.
- MODULUS, 256, count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH.
- PS_WIDTH (localparam), $clog2(PRESCALE) (minimum 1), prescaler register width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  prescaler/count enable
- up_dn  in  1  1 = count up, 0 = count down
- clr  in  1  synchronous clear of counter and prescaler
- load  in  1  synchronous load of counter
- load_val  in  WIDTH  value to load
- count  out  WIDTH  current count (registered)
- tick  out  1  one-cycle pulse each prescale period (registered)
- wrap  out  1  one-cycle pulse when count wraps (registered)

Behaviour:
- Clock and reset: clk is the clock; reset rst_n is synchronous, active-low.
- Reset values: count=0, prescaler=0, tick=0, wrap=0.
- Priority per cycle: rst_n > clr > load > normal operation.
- Prescaler, when en=1:
  - Increments each cycle.
  - When it equals PRESCALE-1, it returns to 0 and generates an internal step.
  - Period is exactly PRESCALE cycles (not PRESCALE+1).
  - PRESCALE=1 gives a step every enabled cycle.
- en=0: prescaler, count and all state hold; tick=0, wrap=0 that cycle.
- tick is registered and high for exactly one cycle: the cycle in which count shows the post-step value.
- Step with up_dn=1: count+1; MODULUS-1 wraps to 0.
- Step with up_dn=0: count-1; 0 wraps to MODULUS-1.
- wrap is registered and asserted coincident with tick only when the step crossed the boundary.
- up_dn is sampled only on the step cycle; changing it between steps has no other effect.
- clr=1: count=0, prescaler=0, tick=0, wrap=0 next cycle, regardless of en or load.
- load=1 (clr=0):
  - count=load_val next cycle; if load_val >= MODULUS, count=MODULUS-1.
  - Prescaler continues unaffected (keeps phase); a coincident step is discarded, load wins.
  - tick still pulses if the prescaler rolled over that cycle; wrap=0.
- Deasserting rst_n mid-period: the period restarts from prescaler 0 after reset is released.
- All arithmetic is modulo/clamped as above; count never holds a value >= MODULUS.

Optional Feature:
- Macro: PRESCALED_COUNTER_SAT_EN.
- Defined: saturating mode.
  - Up-count holds at MODULUS-1; down-count holds at 0.
  - wrap instead pulses on the step that first reaches the limit.
  - Further steps at the limit give tick only, with wrap=0.
- Undefined: wrap-around behaviour as above.

Test Plan:
- Bench parameters: WIDTH=4, PRESCALE=4, MODULUS=10.
- Reset then en=1, up_dn=1 for 44 cycles -> tick every 4th cycle; count 0,1,...,9,0; wrap high once, in the same cycle count goes 9->0; count never reaches 10.
- up_dn=0 from count=0, en=1 -> after 4 cycles count=9 with wrap=1; next steps 8, 7.
- en toggled low for 3 cycles mid-period (prescaler=2) -> count and prescaler frozen; next tick arrives exactly 2 enabled cycles after en returns high.
- load=1, load_val=7 on the same cycle as a step -> count=7 (step discarded), wrap=0; load_val=13 -> count=9.
- clr pulse when prescaler=3, count=5 -> count=0, tick=0 next cycle; next tick 4 enabled cycles later. rst_n low for 1 cycle mid-count -> all outputs 0.
- With PRESCALED_COUNTER_SAT_EN defined, up from 8 -> 9 with wrap=1, then stays 9 with tick pulses and wrap=0.
